// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences data-memory loads, stores and sub-word read-modify-writes
module mem_access_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       st_data_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [2:0]        sh_sel,
  output logic [31:0]       st_data,
  output logic              mdr_en,
  output logic              busy,
  output logic              done,
  output logic              exc
);
  typedef enum logic [2:0] {IDLE, READ, LOAD, WRITE, EXC} state_t;
  state_t state, state_n;
  logic [2:0] op_q, op_n, cnt;
  logic accept, bad;
  assign accept = state == IDLE && start;
  assign op_n = accept ? op : op_q;
  // illegal op, or halfword/word access off its natural boundary
  always_comb bad = op[2:1] == 2'b11 || ((op == 3'b010 || op == 3'b101) && addr[0]) ||
                    ((op == 3'b001 || op == 3'b100) && addr[1:0] != 2'b00);
  // next state: sw writes directly, everything else legal waits out the read latency
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = bad ? EXC : op == 3'b001 ? WRITE : READ;
      READ:  if (cnt == 3'd1) state_n = op_q >= 3'b011 ? LOAD : WRITE;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // request capture and read-latency counter; exceptions leave mem_addr untouched
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_q <= 3'b111;
      st_data <= '0;
      mem_addr <= '0;
      cnt <= '0;
    end else if (accept) begin
      op_q <= op;
      st_data <= st_data_in;
      if (!bad) mem_addr <= addr;
      cnt <= 3'(MEM_LAT);
    end else if (state == READ) cnt <= cnt - 3'd1;
  // Moore outputs registered from the upcoming state so they are glitch-free
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem_wr <= 1'b0;
      mdr_en <= 1'b0;
      done <= 1'b0;
      exc <= 1'b0;
      busy <= 1'b0;
      sh_sel <= 3'b111;
    end else begin
      mem_wr <= state_n == WRITE;
      mdr_en <= state_n == LOAD;
      done <= state_n == LOAD || state_n == WRITE || state_n == EXC;
      exc <= state_n == EXC;
      busy <= state_n != IDLE;
      sh_sel <= (state_n == LOAD || state_n == WRITE) ? op_n : 3'b111;
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of the access sequencer at read latencies 1 and 3
module tb_mem_access_ctrl;
  logic clk = 0, reset = 1, start = 0;
  logic [2:0] op = 0;
  logic [31:0] addr = 0, st_data_in = 0;
  logic [31:0] mem_addr_1, st_data_1, mem_addr_3, st_data_3;
  logic [2:0] sh_sel_1, sh_sel_3;
  logic mem_wr_1, mdr_en_1, busy_1, done_1, exc_1;
  logic mem_wr_3, mdr_en_3, busy_3, done_3, exc_3;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LAT(1), .ADDR_W(32)) u1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .st_data_in(st_data_in),
    .mem_addr(mem_addr_1), .mem_wr(mem_wr_1), .sh_sel(sh_sel_1), .st_data(st_data_1),
    .mdr_en(mdr_en_1), .busy(busy_1), .done(done_1), .exc(exc_1));

  mem_access_ctrl #(.MEM_LAT(3), .ADDR_W(32)) u3 (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .st_data_in(st_data_in),
    .mem_addr(mem_addr_3), .mem_wr(mem_wr_3), .sh_sel(sh_sel_3), .st_data(st_data_3),
    .mdr_en(mdr_en_3), .busy(busy_3), .done(done_3), .exc(exc_3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drive one request at a negedge; returns just after the accepting edge
  task automatic req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    start = 1; op = o; addr = a; st_data_in = d;
    @(posedge clk);
    #1 start = 0; op = 3'b111; addr = '1; st_data_in = 32'h0BAD_0BAD;
  endtask

  logic [2:0] eop [4] = '{3'b101, 3'b100, 3'b110, 3'b010};
  logic [31:0] eaddr [4] = '{32'h13, 32'h12, 32'h40, 32'h21};

  initial begin
    repeat (2) @(negedge clk);
    chk("rst mem_addr", mem_addr_3, 0);
    chk("rst sh_sel", 32'(sh_sel_3), 7);
    chk("rst busy", 32'(busy_3), 0);
    chk("rst done", 32'(done_1), 0);
    chk("rst exc", 32'(exc_1), 0);
    chk("rst st_data", st_data_1, 0);
    chk("rst mem_wr", 32'(mem_wr_1), 0);
    chk("rst mdr_en", 32'(mdr_en_3), 0);
    reset = 0;
    @(negedge clk);
    // lw at 0x10
    req(3'b100, 32'h10, 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("lw mem_addr_1", mem_addr_1, 32'h10);
      chk("lw mem_wr_1", 32'(mem_wr_1), 0);
      chk("lw mem_wr_3", 32'(mem_wr_3), 0);
      chk("lw mdr_en_1", 32'(mdr_en_1), 32'(c == 2));
      chk("lw done_1", 32'(done_1), 32'(c == 2));
      chk("lw sh_sel_1", 32'(sh_sel_1), c == 2 ? 4 : 7);
      chk("lw busy_1", 32'(busy_1), 32'(c <= 2));
      chk("lw mdr_en_3", 32'(mdr_en_3), 32'(c == 4));
      chk("lw done_3", 32'(done_3), 32'(c == 4));
      chk("lw sh_sel_3", 32'(sh_sel_3), c == 4 ? 4 : 7);
      chk("lw busy_3", 32'(busy_3), 32'(c <= 4));
    end
    // sw at 0x20
    req(3'b001, 32'h20, 32'hAABBCCDD);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk("sw mem_addr", mem_addr_3, 32'h20);
      chk("sw st_data", st_data_3, 32'hAABBCCDD);
      chk("sw sh_sel", 32'(sh_sel_3), c == 1 ? 1 : 7);
      chk("sw mem_wr_1", 32'(mem_wr_1), 32'(c == 1));
      chk("sw mem_wr_3", 32'(mem_wr_3), 32'(c == 1));
      chk("sw done", 32'(done_3), 32'(c == 1));
      chk("sw busy", 32'(busy_3), 32'(c == 1));
    end
    // sh at 0x22: read-modify-write
    req(3'b010, 32'h22, 32'h1234);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("sh mem_addr", mem_addr_3, 32'h22);
      chk("sh mem_wr_3", 32'(mem_wr_3), 32'(c == 4));
      chk("sh done_3", 32'(done_3), 32'(c == 4));
      chk("sh sh_sel_3", 32'(sh_sel_3), c == 4 ? 2 : 7);
      chk("sh mem_wr_1", 32'(mem_wr_1), 32'(c == 2));
      chk("sh sh_sel_1", 32'(sh_sel_1), c == 2 ? 2 : 7);
    end
    // misaligned / illegal requests
    for (int i = 0; i < 4; i++) begin
      req(eop[i], eaddr[i], 32'h77);
      @(negedge clk);
      chk("exc exc", 32'(exc_3), 1);
      chk("exc exc_1", 32'(exc_1), 1);
      chk("exc done", 32'(done_3), 1);
      chk("exc mem_wr", 32'(mem_wr_3), 0);
      chk("exc mdr_en", 32'(mdr_en_3), 0);
      chk("exc sh_sel", 32'(sh_sel_3), 7);
      chk("exc mem_addr", mem_addr_3, 32'h22);
      @(negedge clk);
      chk("exc end exc", 32'(exc_3), 0);
      chk("exc end busy", 32'(busy_3), 0);
    end
    // sb at an odd address is legal
    req(3'b000, 32'h03, 32'hFF);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("sb exc", 32'(exc_3), 0);
      chk("sb mem_addr", mem_addr_3, 32'h03);
      chk("sb mem_wr", 32'(mem_wr_3), 32'(c == 4));
      chk("sb sh_sel", 32'(sh_sel_3), c == 4 ? 0 : 7);
    end
    // lb with starts during READ and the done cycle, then a back-to-back sw
    req(3'b011, 32'h05, 0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("busy done", 32'(done_3), 32'(c == 4 || c == 6));
      chk("busy mdr_en", 32'(mdr_en_3), 32'(c == 4));
      chk("busy mem_wr", 32'(mem_wr_3), 32'(c == 6));
      chk("busy mem_addr", mem_addr_3, c <= 5 ? 32'h05 : 32'h40);
      chk("busy busy", 32'(busy_3), 32'(c != 5 && c != 7));
      start = (c == 2 || c == 4 || c == 5);
      op = 3'b001; addr = 32'h40; st_data_in = 32'h11;
    end
    start = 0;
    repeat (3) @(negedge clk);
    // reset in the middle of READ
    req(3'b101, 32'h30, 32'hDEAD);
    @(negedge clk);
    chk("rr busy pre", 32'(busy_3), 1);
    chk("rr mem_addr pre", mem_addr_3, 32'h30);
    @(negedge clk);
    #1 reset = 1;
    #1;
    chk("rr busy", 32'(busy_3), 0);
    chk("rr mem_addr", mem_addr_3, 0);
    chk("rr st_data", st_data_3, 0);
    chk("rr sh_sel", 32'(sh_sel_3), 7);
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rr no done", 32'(done_3), 0);
    end
    req(3'b001, 32'h50, 32'h5555);
    @(negedge clk);
    chk("rr sw mem_wr", 32'(mem_wr_3), 1);
    chk("rr sw done", 32'(done_3), 1);
    chk("rr sw mem_addr", mem_addr_3, 32'h50);
    chk("rr sw st_data", st_data_3, 32'h5555);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for all data-memory accesses of the multicycle CPU. It accepts one load/store request from the main control unit and drives the memory address, the memory write strobe and the size-handler mux select. It also drives the MDR load enable and the latched store operand. Sub-word stores (sb/sh) use a read-modify-write sequence. Misaligned or illegal requests raise an exception without touching memory.

## Interface
- MEM_LAT, 1: memory read latency in cycles, from address stable to read data valid; legal range 1..7.
- ADDR_W, 32: address width.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only when busy=0.
- op  in  3  access code: 000 sb, 001 sw, 010 sh, 011 lb, 100 lw, 101 lh; 110/111 illegal.
- addr  in  ADDR_W  byte address of the access; sampled with start.
- st_data_in  in  32  store operand (register B); sampled with start.
- mem_addr  out  ADDR_W  address to data memory; registered.
- mem_wr  out  1  memory write strobe; registered.
- sh_sel  out  3  size-handler mux select; registered; 111 = pass-through.
- st_data  out  32  latched store operand, fed to the size handler B input.
- mdr_en  out  1  MDR load enable; captures the size-handler output.
- busy  out  1  high from the accepting edge until the end of the done cycle.
- done  out  1  one-cycle completion pulse.
- exc  out  1  one-cycle misalignment/illegal-op pulse, coincident with done.

## Operation
- States: IDLE, READ, LOAD, WRITE, EXC. All outputs are Moore, decoded and registered from the state.
- IDLE with start=1 (the accepting edge):
  - Latch op, addr and st_data_in.
  - Check alignment. Illegal op, lh/sh with addr[0]=1, or lw/sw with addr[1:0]≠00 -> EXC.
  - sw -> WRITE.
  - All other legal ops -> READ; load the wait counter with MEM_LAT.
- READ: mem_addr = latched addr, mem_wr=0, sh_sel=111. The counter decrements each cycle. When it reaches 1: loads -> LOAD, sb/sh -> WRITE.
- LOAD (1 cycle): sh_sel = op, mdr_en=1, done=1 -> IDLE.
- WRITE (1 cycle): sh_sel = op, mem_wr=1, done=1 -> IDLE.
  - mem_addr is unchanged from READ, so the memory read data still holds the old word for the merge.
- EXC (1 cycle): exc=1, done=1, mem_wr=0, mdr_en=0 -> IDLE. mem_addr keeps its previous value, so no access is issued.
- IDLE outputs: sh_sel=111, mem_wr=0, mdr_en=0, done=0, busy=0. mem_addr and st_data hold their last values.
- sb has no alignment restriction. sh_sel equals op whenever sh_sel≠111.

## Timing
- Reset values: state IDLE, mem_addr=0, mem_wr=0, sh_sel=111, st_data=0, mdr_en=0, busy=0, done=0, exc=0.
- Cycle 0 is the accepting edge. Outputs reflecting the request are valid in cycle 1.
- Latency from start to done:
  - sw: done in cycle 1.
  - Loads, sb, sh: done in cycle MEM_LAT+1.
  - Exceptions: done in cycle 1.
- mem_wr is high for exactly one cycle per store and never during loads or exceptions.
- mdr_en is high for exactly one cycle per load.
- start while busy=1 is ignored, including during the done cycle. The next request can be accepted at the edge ending the done cycle (back-to-back accepted at done+1).
- op, addr and st_data_in may change freely after the accepting edge.
- Reset asserted mid-operation forces all outputs to reset values immediately (asynchronously).
  - A store interrupted in WRITE may or may not commit, depending on the memory edge.
  - No done or exc pulse is generated for the aborted access.
- Reset deassertion is synchronised externally; the first accept is possible at the first edge after deassertion.

## Test plan
- lw at 0x10, MEM_LAT=1 -> mem_addr=0x10 in cycles 1–2; cycle 2: sh_sel=100, mdr_en=1, done=1; mem_wr=0 throughout; busy drops in cycle 3.
- sw at 0x20, st_data_in=0xAABBCCDD -> cycle 1: mem_addr=0x20, st_data=0xAABBCCDD, sh_sel=001, mem_wr=1, done=1; no READ state.
- sh at 0x22, MEM_LAT=3 -> READ for cycles 1–3 (mem_wr=0); cycle 4: sh_sel=010, mem_wr=1, done=1, mem_addr=0x22.
- Misaligned requests and illegal op:
  - lh at 0x13 -> cycle 1: exc=1, done=1, mem_wr=0, mdr_en=0, mem_addr unchanged.
  - lw at 0x12 -> same response.
  - op=110 -> same response.
- Busy handling: lb at 0x05 followed by a start pulse during READ -> second request ignored, one done pulse. A start presented in cycle done+1 is accepted.
- Reset during READ (MEM_LAT=3, cycle 2) -> all outputs return to reset values immediately; no done pulse; a new sw after release completes normally.
